// File: rtl/scan_program_sequencer.sv
// scan_program_sequencer
//
// Runs one load-and-run session of the accumulator microcontroller:
// it takes a program/state image as a byte stream, shifts it MSB first
// into the microcontroller scan chain, then enables the core until it
// halts or the watchdog expires, counting execution cycles.
//
// Parameters:
//   CHAIN_LEN       scan chain length in bits (non-zero multiple of 8)
//   MAX_RUN_CYCLES  watchdog limit on RUN cycles (1..65535)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, abort                session control pulses (abort wins)
//   in_data/in_valid/in_ready   image byte stream handshake
//   uc_scan_enable/uc_scan_in   scan chain drive
//   uc_scan_out                 scan chain return (readback only)
//   uc_proc_en, uc_halt         core enable / halt status
//   busy, done, timeout         session status (timeout sticky)
//   run_cycles                  RUN cycles of the last/current session
//   rd_data, rd_valid           readback of the previous chain contents
//
// Optional feature macro: SCAN_READBACK_EN builds the readback capture
// path; without it rd_data/rd_valid are tied to zero.

module scan_program_sequencer #(
    parameter int CHAIN_LEN      = 288,
    parameter int MAX_RUN_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        uc_scan_enable,
    output logic        uc_scan_in,
    input  logic        uc_scan_out,
    output logic        uc_proc_en,
    input  logic        uc_halt,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] run_cycles,
    output logic [7:0]  rd_data,
    output logic        rd_valid
);

    localparam int CW_MIN = $clog2(CHAIN_LEN + 1);
    localparam int CW     = (CW_MIN > 9) ? CW_MIN : 9;

    localparam logic [CW-1:0] LAST_BIT  = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CHAIN_BITS = CW'(CHAIN_LEN);
    localparam logic [15:0]   LAST_RUN  = 16'(MAX_RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [7:0]      shreg;      // remaining bits of the byte in flight, MSB next
    logic [2:0]      bits_left;  // bits still to present after the current one
    logic [CW-1:0]   bit_cnt;    // bits consumed by the chain this session
    logic [CW-1:0]   acc_cnt;    // bits accepted from the byte stream this session

    logic accept;
    logic room;
    logic last_shift;

    assign accept     = (state == S_LOAD) && in_valid && in_ready;
    // More bytes are still owed to the chain.
    assign room       = (acc_cnt != CHAIN_BITS);
    // The edge that consumes the final chain bit.
    assign last_shift = uc_scan_enable && (bits_left == 3'd0) && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            shreg          <= '0;
            bits_left      <= '0;
            bit_cnt        <= '0;
            acc_cnt        <= '0;
            in_ready       <= 1'b0;
            uc_scan_enable <= 1'b0;
            uc_scan_in     <= 1'b0;
            uc_proc_en     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            run_cycles     <= '0;
        end else if (abort) begin
            // run_cycles and timeout are deliberately held.
            state          <= S_IDLE;
            bits_left      <= '0;
            in_ready       <= 1'b0;
            uc_scan_enable <= 1'b0;
            uc_scan_in     <= 1'b0;
            uc_proc_en     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        bit_cnt    <= '0;
                        acc_cnt    <= '0;
                        bits_left  <= '0;
                        run_cycles <= '0;
                        timeout    <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        // Bit 7 goes out now; bits 6..0 wait in shreg.
                        shreg          <= {in_data[6:0], 1'b0};
                        uc_scan_in     <= in_data[7];
                        uc_scan_enable <= 1'b1;
                        bits_left      <= 3'd7;
                        acc_cnt        <= acc_cnt + CW'(8);
                        in_ready       <= 1'b0;
                    end else if (uc_scan_enable && (bits_left != 3'd0)) begin
                        uc_scan_in <= shreg[7];
                        shreg      <= {shreg[6:0], 1'b0};
                        bits_left  <= bits_left - 3'd1;
                        // Open the handshake during the 8th shift cycle so
                        // back-to-back bytes leave no gap.
                        in_ready   <= (bits_left == 3'd1) && room;
                    end else if (uc_scan_enable) begin
                        uc_scan_enable <= 1'b0;
                        uc_scan_in     <= 1'b0;
                        in_ready       <= room;
                    end else begin
                        in_ready <= room;
                    end

                    if (uc_scan_enable) begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end

                    if (last_shift) begin
                        state      <= S_RUN;
                        uc_proc_en <= 1'b1;
                        in_ready   <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (run_cycles != 16'hFFFF) begin
                        run_cycles <= run_cycles + 16'd1;
                    end
                    if (uc_halt) begin
                        state      <= S_DONE;
                        uc_proc_en <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else if (run_cycles == LAST_RUN) begin
                        state      <= S_DONE;
                        uc_proc_en <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SCAN_READBACK_EN
    logic [7:0] cap;
    logic [2:0] cap_cnt;

    // The bit present on uc_scan_out at a shift edge is the one leaving
    // the chain, so eight consecutive samples form one old chain byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap      <= '0;
            cap_cnt  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (abort) begin
            cap_cnt  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (uc_scan_enable) begin
                cap     <= {cap[6:0], uc_scan_out};
                cap_cnt <= cap_cnt + 3'd1;
                if (cap_cnt == 3'd7) begin
                    rd_data  <= {cap[6:0], uc_scan_out};
                    rd_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_scan_out;
    assign unused_scan_out = uc_scan_out;
    assign rd_data         = '0;
    assign rd_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_scan_program_sequencer.sv
// tb_scan_program_sequencer
//
// Drives scan_program_sequencer through full sessions with random images,
// random input gaps and random halt points. The microcontroller scan chain
// is modelled as a plain shift register; expected chain contents, run cycle
// counts, timeout flags and readback bytes are derived from the image bytes
// and the session rules.

module tb_scan_program_sequencer;

    localparam int L    = 288;
    localparam int NB   = L / 8;
    localparam int MAXR = 20;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        uc_scan_enable;
    logic        uc_scan_in;
    logic        uc_scan_out;
    logic        uc_proc_en;
    logic        uc_halt;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] run_cycles;
    logic [7:0]  rd_data;
    logic        rd_valid;

    int vectors     = 0;
    int miscompares = 0;

    scan_program_sequencer #(
        .CHAIN_LEN      (L),
        .MAX_RUN_CYCLES (MAXR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .uc_scan_enable (uc_scan_enable),
        .uc_scan_in     (uc_scan_in),
        .uc_scan_out    (uc_scan_out),
        .uc_proc_en     (uc_proc_en),
        .uc_halt        (uc_halt),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .run_cycles     (run_cycles),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Microcontroller scan chain: first bit in ends up at the top.
    logic [L-1:0] chain = '0;
    always @(posedge clk) begin
        if (uc_scan_enable) chain <= {chain[L-2:0], uc_scan_in};
    end
    assign uc_scan_out = chain[L-1];

    int cyc    = 0;
    int en_cnt = 0;
    int rd_bad = 0;
    logic [7:0] rd_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (uc_scan_enable) en_cnt <= en_cnt + 1;
        if (rd_valid === 1'b1) rd_q.push_back(rd_data);
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) rd_bad <= rd_bad + 1;
    end

    logic [7:0] img [NB];

    task automatic chk(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers img[0..n-1]; returns the cycle of the first handshake.
    task automatic feed(input int n, input bit gaps, output int first_acc, output bit ok);
        int idx   = 0;
        int guard = 0;
        first_acc = -1;
        while (idx < n && guard < 4000) begin
            in_data  = img[idx];
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            uc_halt  = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        uc_halt  = 1'b0;
        ok = (idx == n);
    endtask

    // halt_at: RUN cycle (1-based) on which halt is sampled, 0 = never.
    // abort_after: RUN edges before abort+start are raised, -1 = no abort.
    task automatic run_session(input int halt_at, input bit gaps, input bit timing, input int abort_after);
        logic [L-1:0] exp_img;
        logic [L-1:0] old_chain;
        int first_acc, en0, rb0, k, exp_rc;
        bit ok, exp_to;

        exp_img = '0;
        for (int i = 0; i < NB; i++) exp_img = {exp_img[L-9:0], img[i]};
        old_chain = chain;
        en0 = en_cnt;
        rb0 = rd_q.size();

        pulse_start();
        chk("load_busy", busy, 1);
        chk("load_in_ready", in_ready, 1);
        chk("load_timeout_clr", timeout, 0);
        chk("load_run_cycles_clr", run_cycles, 0);

        feed(NB, gaps, first_acc, ok);
        chk("feed_complete", ok, 1);

        k = 0;
        while (!uc_proc_en && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("proc_en_rise", uc_proc_en, 1);
        if (timing) chk("load_latency", cyc - first_acc, L + 1);
        chk("run_scan_enable", uc_scan_enable, 0);
        chk("run_in_ready", in_ready, 0);
        chk("scan_en_cycles", en_cnt - en0, L);
        chk("chain_image", chain, exp_img);

        if (abort_after >= 0) begin
            repeat (abort_after) @(negedge clk);
            abort = 1'b1;
            start = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            chk("abort_proc_en", uc_proc_en, 0);
            chk("abort_busy", busy, 0);
            chk("abort_run_cycles_held", run_cycles, abort_after);
            repeat (5) @(negedge clk);
            chk("abort_no_load", {busy, in_ready, uc_scan_enable, done}, 0);
            return;
        end

        k = 0;
        while (!done && k < 200) begin
            uc_halt = (halt_at != 0) && (k == halt_at - 1);
            @(negedge clk);
            k++;
        end
        uc_halt = 1'b0;

        if (halt_at != 0 && halt_at <= MAXR) begin
            exp_rc = halt_at;
            exp_to = 1'b0;
        end else begin
            exp_rc = MAXR;
            exp_to = 1'b1;
        end
        chk("done", done, 1);
        chk("done_proc_en", uc_proc_en, 0);
        chk("done_busy", busy, 0);
        chk("run_cycles", run_cycles, exp_rc);
        chk("timeout", timeout, exp_to);

`ifdef SCAN_READBACK_EN
        chk("rb_count", rd_q.size() - rb0, NB);
        for (int b = 0; b < NB && rb0 + b < rd_q.size(); b++)
            chk("rb_byte", rd_q[rb0 + b], old_chain[L-1-8*b -: 8]);
`else
        chk("rb_none", rd_q.size() - rb0, 0);
`endif
    endtask

    initial begin
        int fa;
        bit ok;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; uc_halt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {in_ready, uc_scan_enable, uc_scan_in, uc_proc_en,
                            busy, done, timeout, rd_valid}, 0);
        chk("rst_run_cycles", run_cycles, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a load.
        for (int i = 0; i < NB; i++) img[i] = 8'($urandom());
        pulse_start();
        feed(3, 1'b0, fa, ok);
        chk("partial_feed", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midload_rst", {busy, uc_scan_enable, in_ready, uc_proc_en}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NB; i++) img[i] = 8'hA5;
        run_session(10, 1'b0, 1'b1, -1);

        for (int i = 0; i < NB; i++) img[i] = 8'h3C;
        run_session(int'($urandom_range(1, MAXR - 1)), 1'b0, 1'b1, -1);

        for (int i = 0; i < NB; i++) img[i] = 8'hFF;
        run_session(0, 1'b0, 1'b1, -1);

        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < NB; i++) img[i] = 8'($urandom());
            run_session(int'($urandom_range(1, 30)), 1'b1, 1'b0, -1);
        end

        for (int i = 0; i < NB; i++) img[i] = 8'($urandom());
        run_session(0, 1'b0, 1'b1, 5);

        for (int i = 0; i < NB; i++) img[i] = 8'($urandom());
        run_session(MAXR, 1'b1, 1'b0, -1);

`ifndef SCAN_READBACK_EN
        chk("rd_constant_zero", rd_bad, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
